// File: rtl/pci_ram_arbiter.sv
// pci_ram_arbiter: owns the IO RAM behind the PCI IO target and shares it
// between the PCI data-phase path and a local capture/config engine.
//
// Ports:
//   PCI_CLK, PCI_RSTn             clock (rising edge), async active-low reset
//   pci_req/we/addr/wdata         PCI-side request, held until pci_ack
//   pci_ack                       combinational accept for the PCI side
//   pci_rdata/pci_rvalid          registered PCI read data, 1-cycle latency
//   loc_req/we/addr/wdata         local-side request
//   loc_ack                       combinational accept for the local side
//   loc_rdata/loc_rvalid          registered local read data, 1-cycle latency
//   conflict_cnt                  cycles with both sides requesting
//
// Build option: define PCI_RAM_ARB_STATS_EN to build the saturating
// contention counter; otherwise conflict_cnt is tied to zero.

module pci_ram_arbiter #(
    parameter int AW          = 4,
    parameter int DW          = 32,
    parameter int MAX_PCI_RUN = 4
) (
    input  logic          PCI_CLK,
    input  logic          PCI_RSTn,

    input  logic          pci_req,
    input  logic          pci_we,
    input  logic [AW-1:0] pci_addr,
    input  logic [DW-1:0] pci_wdata,
    output logic          pci_ack,
    output logic [DW-1:0] pci_rdata,
    output logic          pci_rvalid,

    input  logic          loc_req,
    input  logic          loc_we,
    input  logic [AW-1:0] loc_addr,
    input  logic [DW-1:0] loc_wdata,
    output logic          loc_ack,
    output logic [DW-1:0] loc_rdata,
    output logic          loc_rvalid,

    output logic [15:0]   conflict_cnt
);

    localparam int         DEPTH   = 1 << AW;
    localparam logic [3:0] MAX_RUN = 4'(MAX_PCI_RUN);

    // Storage; deliberately not reset.
    logic [DW-1:0] mem_q [DEPTH];

    logic [3:0]    run_q,        run_d;
    logic [DW-1:0] pci_rdata_q,  pci_rdata_d;
    logic          pci_rvalid_q, pci_rvalid_d;
    logic [DW-1:0] loc_rdata_q,  loc_rdata_d;
    logic          loc_rvalid_q, loc_rvalid_d;

    logic          wr_en;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_word;

    // Grant: PCI wins contention until it has taken MAX_PCI_RUN slots in
    // a row while local waited. Acks are held low during reset so no
    // access (in particular no RAM write) can happen on a reset edge.
    always_comb begin
        pci_ack = 1'b0;
        loc_ack = 1'b0;
        if (PCI_RSTn) begin
            if (pci_req && (!loc_req || run_q < MAX_RUN)) begin
                pci_ack = 1'b1;
            end else if (loc_req) begin
                loc_ack = 1'b1;
            end
        end
    end

    // Run counter counts PCI wins only while local is actually waiting.
    always_comb begin
        run_d = run_q;
        if (loc_ack || !loc_req) begin
            run_d = 4'd0;
        end else if (pci_ack && run_q < MAX_RUN) begin
            run_d = run_q + 4'd1;
        end
    end

    // Single shared access port: only one side is granted per cycle.
    always_comb begin
        acc_addr = loc_addr;
        wr_data  = loc_wdata;
        wr_en    = loc_ack && loc_we;
        if (pci_ack) begin
            acc_addr = pci_addr;
            wr_data  = pci_wdata;
            wr_en    = pci_we;
        end
    end

    assign rd_word = mem_q[acc_addr];

    always_comb begin
        pci_rvalid_d = pci_ack && !pci_we;
        loc_rvalid_d = loc_ack && !loc_we;
        pci_rdata_d  = pci_rvalid_d ? rd_word : pci_rdata_q;
        loc_rdata_d  = loc_rvalid_d ? rd_word : loc_rdata_q;
    end

    always_ff @(posedge PCI_CLK) begin
        if (wr_en) begin
            mem_q[acc_addr] <= wr_data;
        end
    end

    always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
        if (!PCI_RSTn) begin
            run_q        <= 4'd0;
            pci_rdata_q  <= '0;
            pci_rvalid_q <= 1'b0;
            loc_rdata_q  <= '0;
            loc_rvalid_q <= 1'b0;
        end else begin
            run_q        <= run_d;
            pci_rdata_q  <= pci_rdata_d;
            pci_rvalid_q <= pci_rvalid_d;
            loc_rdata_q  <= loc_rdata_d;
            loc_rvalid_q <= loc_rvalid_d;
        end
    end

    assign pci_rdata  = pci_rdata_q;
    assign pci_rvalid = pci_rvalid_q;
    assign loc_rdata  = loc_rdata_q;
    assign loc_rvalid = loc_rvalid_q;

`ifdef PCI_RAM_ARB_STATS_EN
    logic [15:0] conflict_q, conflict_d;

    always_comb begin
        conflict_d = conflict_q;
        if (pci_req && loc_req && conflict_q != 16'hFFFF) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
        if (!PCI_RSTn) begin
            conflict_q <= 16'd0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pci_ram_arbiter.sv
// tb_pci_ram_arbiter: directed and randomized checks of pci_ram_arbiter
// against a behavioural model of RAM, grant fairness and read latency.

module tb_pci_ram_arbiter;

    localparam int MAX = 4;

    logic        PCI_CLK = 1'b0;
    logic        PCI_RSTn;
    logic        pci_req, pci_we, loc_req, loc_we;
    logic [3:0]  pci_addr, loc_addr;
    logic [31:0] pci_wdata, loc_wdata;
    logic        pci_ack, loc_ack, pci_rvalid, loc_rvalid;
    logic [31:0] pci_rdata, loc_rdata;
    logic [15:0] conflict_cnt;

    pci_ram_arbiter #(.AW(4), .DW(32), .MAX_PCI_RUN(MAX)) dut (
        .PCI_CLK(PCI_CLK), .PCI_RSTn(PCI_RSTn),
        .pci_req(pci_req), .pci_we(pci_we), .pci_addr(pci_addr),
        .pci_wdata(pci_wdata), .pci_ack(pci_ack), .pci_rdata(pci_rdata),
        .pci_rvalid(pci_rvalid),
        .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr),
        .loc_wdata(loc_wdata), .loc_ack(loc_ack), .loc_rdata(loc_rdata),
        .loc_rvalid(loc_rvalid),
        .conflict_cnt(conflict_cnt)
    );

    always #5 PCI_CLK = ~PCI_CLK;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic [31:0] m_ram [16];
    int          m_streak;
    logic [31:0] m_prd, m_lrd;
    int          m_conf;

    // Expected / observed per step
    logic        e_pack, e_lack, e_prv, e_lrv;
    logic [31:0] e_prd, e_lrd;
    logic        o_pack, o_lack, o_prv, o_lrv;
    logic [31:0] o_prd, o_lrd;

    function automatic logic [15:0] exp_conf();
`ifdef PCI_RAM_ARB_STATS_EN
        return 16'(m_conf);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model(input logic pr, pw, input logic [3:0] pa,
                         input logic [31:0] pd, input logic lr, lw,
                         input logic [3:0] la, input logic [31:0] ld);
        if (pr && lr) begin
            e_pack = (m_streak < MAX);
            e_lack = !e_pack;
            if (m_conf < 65535) m_conf++;
        end else begin
            e_pack = pr;
            e_lack = lr;
        end
        e_prv = e_pack && !pw;
        e_lrv = e_lack && !lw;
        if (e_prv) m_prd = m_ram[pa];
        if (e_lrv) m_lrd = m_ram[la];
        if (e_pack && pw) m_ram[pa] = pd;
        if (e_lack && lw) m_ram[la] = ld;
        e_prd = m_prd;
        e_lrd = m_lrd;
        if (!lr || e_lack) m_streak = 0;
        else if (m_streak < MAX) m_streak++;
    endtask

    // Drive one cycle of requests from posedge+1; acks sampled just before
    // the next edge, read outputs sampled 1 time unit after it.
    task automatic step(input logic pr, pw, input logic [3:0] pa,
                        input logic [31:0] pd, input logic lr, lw,
                        input logic [3:0] la, input logic [31:0] ld);
        pci_req = pr; pci_we = pw; pci_addr = pa; pci_wdata = pd;
        loc_req = lr; loc_we = lw; loc_addr = la; loc_wdata = ld;
        model(pr, pw, pa, pd, lr, lw, la, ld);
        #3;
        o_pack = pci_ack;
        o_lack = loc_ack;
        @(posedge PCI_CLK);
        #1;
        o_prv = pci_rvalid; o_prd = pci_rdata;
        o_lrv = loc_rvalid; o_lrd = loc_rdata;
    endtask

    task automatic model_reset();
        m_streak = 0; m_prd = '0; m_lrd = '0; m_conf = 0;
    endtask

    task automatic test_reset();
        PCI_RSTn = 1'b0;
        pci_req = 1'b1; pci_we = 1'b1; pci_addr = 4'd1; pci_wdata = '1;
        loc_req = 1'b1; loc_we = 1'b1; loc_addr = 4'd2; loc_wdata = '1;
        model_reset();
        #2;
        n_total++;
        if (pci_ack !== 1'b0 || loc_ack !== 1'b0)
            $display("FAIL reset_acks got %b%b want 00", pci_ack, loc_ack);
        else n_pass++;
        repeat (2) @(posedge PCI_CLK);
        #1;
        n_total++;
        if (pci_rvalid !== 1'b0 || loc_rvalid !== 1'b0)
            $display("FAIL reset_rvalid got %b%b want 00", pci_rvalid, loc_rvalid);
        else n_pass++;
        n_total++;
        if (pci_rdata !== 32'd0 || loc_rdata !== 32'd0)
            $display("FAIL reset_rdata got %h %h want 0", pci_rdata, loc_rdata);
        else n_pass++;
        n_total++;
        if (conflict_cnt !== 16'd0)
            $display("FAIL reset_conflict got %0d want 0", conflict_cnt);
        else n_pass++;
        pci_req = 1'b0; loc_req = 1'b0;
        @(negedge PCI_CLK);
        PCI_RSTn = 1'b1;
        @(posedge PCI_CLK);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d;
            d = $urandom;
            if (i[0]) step(1'b0, 1'b0, 4'd0, '0, 1'b1, 1'b1, 4'(i), d);
            else      step(1'b1, 1'b1, 4'(i), d, 1'b0, 1'b0, 4'd0, '0);
            n_total++;
            if (o_pack !== e_pack || o_lack !== e_lack)
                $display("FAIL fill_ack[%0d] got %b%b want %b%b",
                         i, o_pack, o_lack, e_pack, e_lack);
            else n_pass++;
        end
    endtask

    task automatic test_pci_rw();
        step(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, '0);
        n_total++;
        if (o_pack !== 1'b1)
            $display("FAIL pci_write_ack got %b want 1", o_pack);
        else n_pass++;
        step(1'b1, 1'b0, 4'd3, '0, 1'b0, 1'b0, 4'd0, '0);
        n_total++;
        if (o_pack !== 1'b1)
            $display("FAIL pci_read_ack got %b want 1", o_pack);
        else n_pass++;
        n_total++;
        if (o_prv !== 1'b1 || o_prd !== 32'hDEADBEEF)
            $display("FAIL pci_read_data got %b %h want 1 deadbeef", o_prv, o_prd);
        else n_pass++;
        n_total++;
        if (o_lrv !== 1'b0)
            $display("FAIL pci_read_locrv got %b want 0", o_lrv);
        else n_pass++;
        step(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 4'd0, '0);
        n_total++;
        if (o_prv !== 1'b0 || o_prd !== 32'hDEADBEEF)
            $display("FAIL pci_rvalid_drop got %b %h want 0 deadbeef", o_prv, o_prd);
        else n_pass++;
    endtask

    task automatic test_loc_write();
        step(1'b0, 1'b0, 4'd0, '0, 1'b1, 1'b1, 4'd15, 32'h12345678);
        n_total++;
        if (o_lack !== 1'b1 || o_pack !== 1'b0)
            $display("FAIL loc_write_ack got %b%b want 01", o_pack, o_lack);
        else n_pass++;
        step(1'b1, 1'b0, 4'd15, '0, 1'b0, 1'b0, 4'd0, '0);
        n_total++;
        if (o_prv !== 1'b1 || o_prd !== 32'h12345678)
            $display("FAIL loc_write_readback got %b %h want 1 12345678", o_prv, o_prd);
        else n_pass++;
    endtask

    task automatic test_fairness();
        for (int i = 0; i < 15; i++) begin
            logic want_l;
            want_l = (i % 5) == 4;
            step(1'b1, 1'b0, 4'($urandom), '0, 1'b1, 1'b0, 4'($urandom), '0);
            n_total++;
            if (o_pack !== !want_l || o_lack !== want_l)
                $display("FAIL fair_pattern[%0d] got %b%b want %b%b",
                         i, o_pack, o_lack, !want_l, want_l);
            else n_pass++;
            n_total++;
            if (o_prd !== e_prd || o_lrd !== e_lrd)
                $display("FAIL fair_rdata[%0d] got %h %h want %h %h",
                         i, o_prd, o_lrd, e_prd, e_lrd);
            else n_pass++;
        end
        step(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 4'd0, '0);
    endtask

    task automatic test_loc_drop();
        string pat;
        step(1'b0, 1'b0, 4'd0, '0, 1'b1, 1'b0, 4'd0, '0);
        n_total++;
        if (o_lrv !== 1'b1 || o_lrd !== m_ram[0])
            $display("FAIL loc_read0 got %b %h want 1 %h", o_lrv, o_lrd, m_ram[0]);
        else n_pass++;
        pat = "PPPPPPPL";
        for (int i = 0; i < 8; i++) begin
            logic lr, want_l;
            lr = (i != 2);
            want_l = (pat[i] == "L");
            step(1'b1, 1'b0, 4'(i), '0, lr, 1'b0, 4'(i + 1), '0);
            n_total++;
            if (o_pack !== !want_l || o_lack !== want_l)
                $display("FAIL drop_pattern[%0d] got %b%b want %b%b",
                         i, o_pack, o_lack, !want_l, want_l);
            else n_pass++;
        end
        step(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 4'd0, '0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] keep;
        keep = m_ram[5];
        step(1'b1, 1'b0, 4'd5, '0, 1'b0, 1'b0, 4'd0, '0);
        n_total++;
        if (o_prv !== 1'b1 || o_prd !== keep)
            $display("FAIL premid_read got %b %h want 1 %h", o_prv, o_prd, keep);
        else n_pass++;
        pci_we = 1'b1; pci_wdata = ~keep;
        loc_req = 1'b1; loc_we = 1'b1; loc_addr = 4'd5; loc_wdata = ~keep;
        PCI_RSTn = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (pci_rvalid !== 1'b0)
            $display("FAIL mid_rvalid got %b want 0", pci_rvalid);
        else n_pass++;
        n_total++;
        if (pci_ack !== 1'b0 || loc_ack !== 1'b0)
            $display("FAIL mid_acks got %b%b want 00", pci_ack, loc_ack);
        else n_pass++;
        @(posedge PCI_CLK);
        #1;
        pci_req = 1'b0; loc_req = 1'b0;
        @(negedge PCI_CLK);
        PCI_RSTn = 1'b1;
        @(posedge PCI_CLK);
        #1;
        step(1'b1, 1'b0, 4'd5, '0, 1'b0, 1'b0, 4'd0, '0);
        n_total++;
        if (o_prv !== 1'b1 || o_prd !== keep)
            $display("FAIL postmid_read got %b %h want 1 %h", o_prv, o_prd, keep);
        else n_pass++;
    endtask

    task automatic test_stats();
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 4'(i), '0, 1'b1, 1'b0, 4'(i), '0);
        step(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 4'd0, '0);
        n_total++;
`ifdef PCI_RAM_ARB_STATS_EN
        if (conflict_cnt !== 16'd10)
            $display("FAIL stats_10 got %0d want 10", conflict_cnt);
        else n_pass++;
`else
        if (conflict_cnt !== 16'd0)
            $display("FAIL stats_off got %0d want 0", conflict_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, 1'($urandom), 4'($urandom), $urandom,
                 $urandom_range(0, 9) < 6, 1'($urandom), 4'($urandom), $urandom);
            n_total++;
            if (o_pack !== e_pack || o_lack !== e_lack)
                $display("FAIL rnd_ack[%0d] got %b%b want %b%b",
                         i, o_pack, o_lack, e_pack, e_lack);
            else n_pass++;
            n_total++;
            if (o_prv !== e_prv || o_prd !== e_prd)
                $display("FAIL rnd_pci_rd[%0d] got %b %h want %b %h",
                         i, o_prv, o_prd, e_prv, e_prd);
            else n_pass++;
            n_total++;
            if (o_lrv !== e_lrv || o_lrd !== e_lrd)
                $display("FAIL rnd_loc_rd[%0d] got %b %h want %b %h",
                         i, o_lrv, o_lrd, e_lrv, e_lrd);
            else n_pass++;
        end
        n_total++;
        if (conflict_cnt !== exp_conf())
            $display("FAIL rnd_conflict got %0d want %0d", conflict_cnt, exp_conf());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pci_rw();
        test_loc_write();
        test_fairness();
        test_loc_drop();
        test_reset_mid();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pci_ram_arbiter.md
Name: pci_ram_arbiter

Overview:
- Owns the 16 x 32-bit IO RAM behind the PCI IO target and shares it between two requesters.
  - PCI side: target data-phase logic; latency-critical.
  - Local side: a capture/config engine on the board.
- Grants at most one access per clock.
- PCI gets priority, bounded by a fairness limit so the local side cannot starve.
- Provides registered read data with fixed 1-cycle latency.

Parameters:
- AW, 4, RAM address width (depth = 2**AW words).
- DW, 32, data width.
- MAX_PCI_RUN, 4, consecutive PCI grants allowed while local is waiting before local is forced a slot (range 1..15).

Ports:
- PCI_CLK  in  1  sole clock, rising edge.
- PCI_RSTn  in  1  asynchronous active-low reset.
- pci_req  in  1  PCI-side access request; held until pci_ack.
- pci_we  in  1  1 = write, 0 = read; valid with pci_req.
- pci_addr  in  AW  word address.
- pci_wdata  in  DW  write data.
- pci_ack  out  1  access accepted this cycle (combinational).
- pci_rdata  out  DW  read data, registered.
- pci_rvalid  out  1  pci_rdata valid; 1 cycle after a read ack.
- loc_req, loc_we, loc_addr, loc_wdata  in  1/1/AW/DW  local-side equivalents.
- loc_ack  out  1  local accept.
- loc_rdata  out  DW  local read data, registered.
- loc_rvalid  out  1  local read valid.
- conflict_cnt  out  16  contention statistic (see Optional Feature).

Behaviour:
- Clock/reset: single clock PCI_CLK; reset PCI_RSTn is asynchronous, active-low.
- Reset values: pci_rdata = loc_rdata = 0, pci_rvalid = loc_rvalid = 0, run counter = 0, conflict_cnt = 0.
  - While PCI_RSTn = 0, pci_ack = loc_ack = 0 regardless of requests.
  - RAM contents are not reset.
- Arbitration, combinational from the current requests and the registered run counter:
  - Only pci_req: pci_ack = 1.
  - Only loc_req: loc_ack = 1.
  - Both, and run < MAX_PCI_RUN: pci_ack = 1.
  - Both, and run == MAX_PCI_RUN: loc_ack = 1.
  - pci_ack and loc_ack are never both 1.
- Run counter (registered, 4 bits):
  - Increments when pci_ack = 1 and loc_req = 1.
  - Clears when loc_ack = 1 or loc_req = 0.
  - Saturates at MAX_PCI_RUN.
- Write: on the rising edge with ack & we, RAM[addr] <= wdata of the granted side.
- Read:
  - On the edge with ack & ~we, the granted side's rdata <= RAM[addr] and rvalid <= 1.
  - Otherwise rvalid <= 0 and rdata holds its last value.
  - Read latency is exactly 1 cycle.
- Read-during-write: only one side is granted per cycle, so no same-cycle conflict exists.
  - A read granted the cycle after a write to the same address returns the new data.
- Back-to-back: a requester held on req gets one access per cycle while it is granted.
  - rvalid can be high on consecutive cycles.
- Address aliasing: none; addresses outside 2**AW cannot occur by width.
- Reset asserted mid-operation: pending rvalid is dropped (forced 0 asynchronously), the counter clears, and no RAM write occurs on that edge.

Optional Feature:
- Macro: PCI_RAM_ARB_STATS_EN.
- Defined:
  - conflict_cnt increments on every cycle where pci_req & loc_req = 1.
  - It saturates at 16'hFFFF and clears only on reset.
- Undefined:
  - Counter logic is not built; conflict_cnt is tied to 16'h0000.
  - The port remains, so instantiations are unchanged.

Test Plan:
- Reset, then PCI write 32'hDEADBEEF to addr 3, then PCI read addr 3 -> pci_ack on both cycles; pci_rvalid = 1 one cycle after the read ack; pci_rdata = 32'hDEADBEEF; loc_rvalid stays 0.
- Local write 32'h12345678 to addr 15 while pci_req = 0 -> loc_ack = 1 the same cycle; a subsequent PCI read of addr 15 returns 32'h12345678.
- pci_req and loc_req held continuously with MAX_PCI_RUN = 4 -> grant pattern P,P,P,P,L repeating; pci_ack and loc_ack are never simultaneously 1.
- Local read of addr 0, then loc_req dropped for 1 cycle mid-PCI burst -> run counter clears; the next contended cycles give 4 PCI grants before local.
- PCI_RSTn pulsed low the cycle after a read ack -> pci_rvalid drops to 0 immediately; acks are 0 during reset; a post-reset read of the same address returns the pre-reset contents.
- With PCI_RAM_ARB_STATS_EN defined, 10 contended cycles -> conflict_cnt = 10. Without the macro -> conflict_cnt = 0.
